// File: rtl/alu_seq_pkg.sv
// Shared types and op-codes for the sequential ALU.
package alu_seq_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 2'd0;
    localparam alu_op_t ALU_OP_SUB = 2'd1;
    localparam alu_op_t ALU_OP_MUL = 2'd2;
    localparam alu_op_t ALU_OP_DIV = 2'd3;

    typedef enum logic {StIdle, StBusy} alu_state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// One radix-2 step: shift-add multiply (LSB first) or restoring divide (MSB first).
module alu_seq_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_rem;
    logic [WIDTH:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_i};
        div_rem  = {acc_i, q_i[WIDTH-1]};
        div_diff = div_rem - {1'b0, operand_i};
        acc_o    = acc_i;
        q_o      = q_i;
        if (div_mode_i) begin
            // Remainder stays below the divisor, so it always fits back into WIDTH bits
            if (div_rem >= {1'b0, operand_i}) begin
                acc_o = div_diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = div_rem[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q_i[0]) begin
                mul_sum = {1'b0, acc_i} + {1'b0, operand_i};
            end
            acc_o = mul_sum[WIDTH:1];
            q_o   = {mul_sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked add/sub/mul/div ALU with an iterative radix-2 mul/div datapath.
// Define ALU_SEQ_SIGNED_EN to add the signed_op port for two's-complement mul/div.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
`ifdef ALU_SEQ_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] extra,
    output logic             div_zero
);

    alu_state_t       state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    alu_op_t          op_q, op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] extra_q, extra_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             sgn;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    logic [2*WIDTH-1:0] prod;

`ifdef ALU_SEQ_SIGNED_EN
    assign sgn = signed_op;
`else
    assign sgn = 1'b0;
`endif

    // Signed mul/div runs on magnitudes; the sign is restored on the final edge
    assign mag1    = (sgn && op1[WIDTH-1]) ? -op1 : op1;
    assign mag2    = (sgn && op2[WIDTH-1]) ? -op2 : op2;
    assign add_sum = {1'b0, op1} + {1'b0, op2};
    assign sub_sum = {1'b0, op1} + {1'b0, ~op2} + (WIDTH + 1)'(1);

    alu_seq_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .div_mode_i(op_q == ALU_OP_DIV),
        .acc_i     (acc_q),
        .q_i       (q_q),
        .operand_i (opd_q),
        .acc_o     (acc_nxt),
        .q_o       (q_nxt)
    );

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        acc_d      = acc_q;
        q_d        = q_q;
        opd_d      = opd_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        extra_d    = extra_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        prod       = {acc_nxt, q_nxt};
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    op_d       = control;
                    unique case (control)
                        ALU_OP_ADD: begin
                            result_d = add_sum[WIDTH-1:0];
                            extra_d  = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
                            done_d   = 1'b1;
                        end
                        ALU_OP_SUB: begin
                            result_d = sub_sum[WIDTH-1:0];
                            extra_d  = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH]};
                            done_d   = 1'b1;
                        end
                        default: begin
                            if (control == ALU_OP_DIV && op2 == '0) begin
                                result_d   = '1;
                                extra_d    = op1;
                                div_zero_d = 1'b1;
                                done_d     = 1'b1;
                            end else begin
                                acc_d     = '0;
                                q_d       = mag1;
                                opd_d     = mag2;
                                neg_res_d = sgn && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                                neg_rem_d = sgn && op1[WIDTH-1];
                                ctr_d     = CNT_W'(WIDTH);
                                state_d   = StBusy;
                            end
                        end
                    endcase
                end
            end
            StBusy: begin
                acc_d = acc_nxt;
                q_d   = q_nxt;
                ctr_d = ctr_q - CNT_W'(1);
                if (ctr_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (op_q == ALU_OP_DIV) begin
                        result_d = neg_res_q ? -q_nxt : q_nxt;
                        extra_d  = neg_rem_q ? -acc_nxt : acc_nxt;
                    end else begin
                        if (neg_res_q) begin
                            prod = -{acc_nxt, q_nxt};
                        end
                        result_d = prod[WIDTH-1:0];
                        extra_d  = prod[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ctr_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            opd_q      <= '0;
            op_q       <= ALU_OP_ADD;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            extra_q    <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            opd_q      <= opd_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            extra_q    <= extra_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign result   = result_q;
    assign extra    = extra_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32; signed vectors run under ALU_SEQ_SIGNED_EN.
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  control = 2'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        signed_op = 1'b0;
    logic        ready, done, div_zero;
    logic [31:0] result, extra;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_seq #(
        .WIDTH(32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .control  (control),
        .op1      (op1),
        .op2      (op2),
`ifdef ALU_SEQ_SIGNED_EN
        .signed_op(signed_op),
`endif
        .ready    (ready),
        .done     (done),
        .result   (result),
        .extra    (extra),
        .div_zero (div_zero)
    );

    // Presents one request for a single edge; returns in the cycle after the accept edge.
    task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
        @(negedge clock);
        start = 1'b1; control = c; op1 = a; op2 = b; signed_op = s;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++; if (extra !== 32'h0) begin n_fail++; $display("FAIL reset_extra: got %h want 0", extra); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_divz: got %b want 0", div_zero); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        send(2'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL add_result: got %h want 0", result); end
        n_checks++; if (extra !== 32'h1) begin n_fail++; $display("FAIL add_carry: got %h want 1", extra); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL add_hold: got %h want 0", result); end
        send(2'd1, 32'd7, 32'd5, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sub1_done: got %b want 1", done); end
        n_checks++; if (result !== 32'd2) begin n_fail++; $display("FAIL sub1_result: got %h want 2", result); end
        n_checks++; if (extra !== 32'h1) begin n_fail++; $display("FAIL sub1_carry: got %h want 1", extra); end
        send(2'd1, 32'd5, 32'd7, 1'b0);
        n_checks++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub2_result: got %h want fffffffe", result); end
        n_checks++; if (extra !== 32'h0) begin n_fail++; $display("FAIL sub2_carry: got %h want 0", extra); end
    endtask

    task automatic test_mul();
        int ndone = 0;
        send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            if (i == 4) begin
                start = 1'b1; control = 2'd0; op1 = 32'd1; op2 = 32'd1;
            end
            if (i == 5) start = 1'b0;
            n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy_ready i=%0d: got %b want 0", i, ready); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_early_done i=%0d: got %b want 0", i, done); end
            @(negedge clock);
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_done_latency: got %b want 1", done); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_back: got %b want 1", ready); end
        n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL mul_lo: got %h want 00000001", result); end
        n_checks++; if (extra !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_hi: got %h want fffffffe", extra); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL mul_extra_done: got %0d want 0", ndone); end
    endtask

    task automatic test_div();
        int cyc = 0;
        send(2'd3, 32'd100, 32'd7, 1'b0);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL div_latency: got %0d want 32", cyc); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL div_quot: got %h want 0000000e", result); end
        n_checks++; if (extra !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %h want 2", extra); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_divz: got %b want 0", div_zero); end
        send(2'd3, 32'd9, 32'd0, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dz_done: got %b want 1", done); end
        n_checks++; if (result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_result: got %h want ffffffff", result); end
        n_checks++; if (extra !== 32'd9) begin n_fail++; $display("FAIL dz_extra: got %h want 9", extra); end
        n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL dz_ready: got %b want 1", ready); end
    endtask

    task automatic test_reset_mid_op();
        int ndone = 0;
        send(2'd2, 32'h0001_0003, 32'h0000_0005, 1'b0);
        for (int i = 0; i < 9; i++) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", result); end
        n_checks++; if (extra !== 32'h0) begin n_fail++; $display("FAIL rst_mid_extra: got %h want 0", extra); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_mid_divz: got %b want 0", div_zero); end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1; control = 2'd0; op1 = 32'd3; op2 = 32'd4;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_add_done: got %b want 1", done); end
        n_checks++; if (result !== 32'd7) begin n_fail++; $display("FAIL rst_add_result: got %h want 7", result); end
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_stale_done: got %0d want 0", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] s [4];
        logic [31:0] c [4];
        a[0] = 32'hFFFF_FFFF; b[0] = 32'h1;        s[0] = 32'h0;         c[0] = 32'h1;
        a[1] = 32'h10;        b[1] = 32'h20;       s[1] = 32'h30;        c[1] = 32'h0;
        a[2] = 32'h7FFF_FFFF; b[2] = 32'h1;        s[2] = 32'h8000_0000; c[2] = 32'h0;
        a[3] = 32'h1234;      b[3] = 32'h4321;     s[3] = 32'h5555;      c[3] = 32'h0;
        @(negedge clock);
        start = 1'b1; control = 2'd0; op1 = a[0]; op2 = b[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k < 3) begin
                op1 = a[k+1]; op2 = b[k+1];
            end else begin
                start = 1'b0;
            end
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done k=%0d: got %b want 1", k, done); end
            n_checks++; if (result !== s[k]) begin n_fail++; $display("FAIL b2b_result k=%0d: got %h want %h", k, result, s[k]); end
            n_checks++; if (extra !== c[k]) begin n_fail++; $display("FAIL b2b_carry k=%0d: got %h want %h", k, extra, c[k]); end
        end
        @(negedge clock);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_done: got %b want 0", done); end
    endtask

`ifdef ALU_SEQ_SIGNED_EN
    task automatic test_signed();
        int cyc;
        send(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL sdiv_latency: got %0d want 32", cyc); end
        n_checks++; if (result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_quot: got %h want fffffffd", result); end
        n_checks++; if (extra !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_rem: got %h want ffffffff", extra); end
        send(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL smin_quot: got %h want 80000000", result); end
        n_checks++; if (extra !== 32'h0) begin n_fail++; $display("FAIL smin_rem: got %h want 0", extra); end
        send(2'd2, 32'hFFFF_FFFD, 32'd4, 1'b1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL smul_latency: got %0d want 32", cyc); end
        n_checks++; if (result !== 32'hFFFF_FFF4) begin n_fail++; $display("FAIL smul_lo: got %h want fffffff4", result); end
        n_checks++; if (extra !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL smul_hi: got %h want ffffffff", extra); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_reset_mid_op();
        test_back_to_back();
`ifdef ALU_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
